cdc_tx_scheduler: RTL and testbench

- Source-domain controller that shares one data_synchronizer channel between NUM_REQ requesters.
- Arbitrates requests round-robin and latches the winner's word.
- Drives asynchronous_data_valid/asynchronous_data with a 4-phase handshake. Data stays stable until the destination acknowledges, so the destination's edge-detect capture is always safe.
- Handshake closes on ack_async, a level acknowledge returned from the destination domain and resynchronized locally. Sits beside SYS_CTRL / UART-RX on the source side of each CDC crossing.

---
 rtl/cdc_pkg.sv | 12 +
 rtl/bus_synchronizer.sv | 27 ++
 rtl/cdc_tx_scheduler.sv | 145 ++++++++++++++
 tb/tb_cdc_tx_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the source-side CDC transmit scheduler.
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_STAGE_COUNT = 2;

endpackage

// File: rtl/bus_synchronizer.sv
// Multi-flop resynchronizer for a quasi-static bus into the local clock domain.
module bus_synchronizer #(
  parameter int unsigned BUS_WIDTH   = 1,
  parameter int unsigned STAGE_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BUS_WIDTH-1:0] asynchronous_bus,
  output logic [BUS_WIDTH-1:0] synchronous_bus
);

  logic [STAGE_COUNT-1:0][BUS_WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= asynchronous_bus;
      for (int unsigned i = 1; i < STAGE_COUNT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign synchronous_bus = stage_q[STAGE_COUNT-1];

endmodule

// File: rtl/cdc_tx_scheduler.sv
// Round-robin arbiter driving one 4-phase valid/ack CDC channel from the source domain.
module cdc_tx_scheduler
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BUS_WIDTH      = 8,
  parameter int unsigned STAGE_COUNT    = DEFAULT_STAGE_COUNT,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         ack_async,
  output logic                         asynchronous_data_valid,
  output logic [BUS_WIDTH-1:0]         asynchronous_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         xfer_done,
  output logic                         timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  // Timeout fires on the edge that completes the TIMEOUT_CYCLES-th cycle in a phase.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t               state_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      ptr_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic                 valid_q;
  logic [BUS_WIDTH-1:0] data_q;
  logic [ID_W-1:0]      grant_q;
  logic                 xfer_done_q;
  logic                 timeout_q;

  logic                 ack_sync;
  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  logic [BUS_WIDTH-1:0] win_data;
  int unsigned          cand;

  bus_synchronizer #(
    .BUS_WIDTH   (1),
    .STAGE_COUNT (STAGE_COUNT)
  ) u_ack_sync (
    .clk              (clk),
    .reset_n          (reset_n),
    .asynchronous_bus (ack_async),
    .synchronous_bus  (ack_sync)
  );

  // First asserted request scanning upward from the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
        win_data  = req_data[cand*BUS_WIDTH +: BUS_WIDTH];
      end
    end
    ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      grant_q     <= '0;
      xfer_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      req_ready_q <= '0;
      xfer_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found && !ack_sync) begin
            data_q      <= win_data;
            grant_q     <= win_idx;
            req_ready_q <= NUM_REQ'(1) << win_idx;
            valid_q     <= 1'b1;
            ptr_q       <= ptr_d;
            cnt_q       <= '0;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ack_sync) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RELEASE;
          end else if (TO_EN && cnt_q == TO_LAST) begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_RELEASE;
          end else if (TO_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!ack_sync) begin
            xfer_done_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
          end else if (TO_EN && cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
          end else if (TO_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready               = req_ready_q;
  assign asynchronous_data_valid = valid_q;
  assign asynchronous_data       = data_q;
  assign grant_id                = grant_q;
  assign busy                    = (state_q != ST_IDLE);
  assign xfer_done               = xfer_done_q;
  assign timeout_err             = timeout_q;

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Directed checks of arbitration, handshake timing, stale ack, timeout and async reset.
module tb_cdc_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = 32'h13121110;
  logic [3:0]  req_ready;
  logic        ack_async = 1'b0;
  logic        valid;
  logic [7:0]  data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        xfer_done;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdc_tx_scheduler #(
    .NUM_REQ        (4),
    .BUS_WIDTH      (8),
    .STAGE_COUNT    (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .req_valid               (req_valid),
    .req_data                (req_data),
    .req_ready               (req_ready),
    .ack_async               (ack_async),
    .asynchronous_data_valid (valid),
    .asynchronous_data       (data),
    .grant_id                (grant_id),
    .busy                    (busy),
    .xfer_done               (xfer_done),
    .timeout_err             (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    ack_async = 1'b0;
    req_valid = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Destination model: ack as soon as valid is seen, drop ack once valid falls.
  task automatic handshake(input int id, input logic [7:0] exp_data, input logic [3:0] next_req);
    int n;
    logic [3:0] oh;
    oh = 4'b0001 << id;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("hs_valid_rise", valid, 1);
    chk("hs_grant_id", grant_id, id);
    chk("hs_req_ready", req_ready, oh);
    chk("hs_data", data, exp_data);
    req_valid = next_req;
    ack_async = 1'b1;
    n = 0;
    while (valid === 1'b1 && n < 20) begin
      tick();
      n++;
      chk("hs_data_hold", data, exp_data);
    end
    chk("hs_valid_fall", valid, 0);
    ack_async = 1'b0;
    n = 0;
    while (xfer_done !== 1'b1 && n < 20) begin tick(); n++; end
    chk("hs_xfer_done", xfer_done, 1);
    chk("hs_busy_clear", busy, 0);
  endtask

  initial begin
    // Reset values
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_xfer", xfer_done, 0);
    chk("rst_tmo", timeout_err, 0);
    reset_n = 1'b1;
    tick();

    // Single request, exact cycle timing with ack 3 cycles after valid
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    tick();
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_valid", valid, 1);
    chk("t1_data", data, 8'hA5);
    chk("t1_grant", grant_id, 0);
    chk("t1_busy", busy, 1);
    req_valid = 4'b0000;
    tick();
    chk("t1_ready_pulse", req_ready, 0);
    chk("t1_valid_e2", valid, 1);
    tick();
    tick();
    chk("t1_valid_e4", valid, 1);
    ack_async = 1'b1;
    tick();
    tick();
    chk("t1_valid_e6", valid, 1);
    chk("t1_data_e6", data, 8'hA5);
    tick();
    chk("t1_valid_fall", valid, 0);
    chk("t1_busy_rel", busy, 1);
    chk("t1_data_after", data, 8'hA5);
    ack_async = 1'b0;
    tick();
    tick();
    chk("t1_xfer_e9", xfer_done, 0);
    chk("t1_busy_e9", busy, 1);
    tick();
    chk("t1_xfer_e10", xfer_done, 1);
    chk("t1_busy_e10", busy, 0);
    tick();
    chk("t1_xfer_pulse", xfer_done, 0);

    // Fairness: all four requesting for eight transfers
    req_data = 32'h13121110;
    do_reset();
    req_valid = 4'b1111;
    handshake(0, 8'h10, 4'b1111);
    handshake(1, 8'h11, 4'b1111);
    handshake(2, 8'h12, 4'b1111);
    handshake(3, 8'h13, 4'b1111);
    handshake(0, 8'h10, 4'b1111);
    handshake(1, 8'h11, 4'b1111);
    handshake(2, 8'h12, 4'b1111);
    handshake(3, 8'h13, 4'b0000);

    // Pointer wrap: grant 2 moves pointer to 3, then 0101 gives 0 then 2
    do_reset();
    req_valid = 4'b0100;
    handshake(2, 8'h12, 4'b0000);
    req_valid = 4'b0101;
    handshake(0, 8'h10, 4'b0100);
    handshake(2, 8'h12, 4'b0000);

    // Stale ack held in IDLE
    do_reset();
    ack_async = 1'b1;
    tick();
    tick();
    tick();
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stale_no_ready", req_ready, 0);
      chk("stale_no_valid", valid, 0);
    end
    ack_async = 1'b0;
    tick();
    chk("stale_e1", req_ready, 0);
    tick();
    chk("stale_e2", req_ready, 0);
    tick();
    chk("stale_grant_ready", req_ready, 4'b0010);
    chk("stale_grant_id", grant_id, 1);
    chk("stale_valid", valid, 1);

    // Timeout in SEND, then in RELEASE with ack stuck high
    do_reset();
    req_valid = 4'b0001;
    tick();
    chk("to_grant", valid, 1);
    req_valid = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("to_send_valid", valid, 1);
      chk("to_send_quiet", timeout_err, 0);
      if (i == 6) ack_async = 1'b1;
    end
    tick();
    chk("to_send_err", timeout_err, 1);
    chk("to_send_valid0", valid, 0);
    chk("to_send_busy", busy, 1);
    chk("to_send_noxfer", xfer_done, 0);
    for (int i = 9; i <= 15; i++) begin
      tick();
      chk("to_rel_busy", busy, 1);
      chk("to_rel_quiet", timeout_err, 0);
      chk("to_rel_noxfer", xfer_done, 0);
    end
    tick();
    chk("to_rel_err", timeout_err, 1);
    chk("to_rel_idle", busy, 0);
    chk("to_rel_noxfer_end", xfer_done, 0);
    tick();
    chk("to_err_pulse", timeout_err, 0);
    ack_async = 1'b0;

    // Asynchronous reset mid-SEND, pointer restarts at 0
    do_reset();
    req_valid = 4'b0100;
    tick();
    chk("rs_grant2", grant_id, 2);
    req_valid = 4'b1001;
    tick();
    reset_n = 1'b0;
    #1;
    chk("rs_valid", valid, 0);
    chk("rs_data", data, 0);
    chk("rs_grant", grant_id, 0);
    chk("rs_busy", busy, 0);
    chk("rs_ready", req_ready, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rs_regrant_valid", valid, 1);
    chk("rs_regrant_id", grant_id, 0);
    chk("rs_regrant_ready", req_ready, 4'b0001);
    chk("rs_regrant_data", data, 8'h10);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
